core_result_collector: RTL and testbench

CORE_RESULT_COLLECTOR -- requirements
Module: core_result_collector

---
 rtl/hpu_pkg.sv | 24 ++
 rtl/core_result_collector_if.sv | 33 +++
 rtl/vec_fifo.sv | 58 +++++
 rtl/core_result_collector.sv | 176 +++++++++++++++++
 tb/tb_core_result_collector.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hpu_pkg
// Description : Shared hypervector defaults, words-per-vector helper and the
//               result collector state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package hpu_pkg;

    localparam int c_DIM_DEFAULT  = 1023;
    localparam int c_WORD_DEFAULT = 32;

    function automatic int wpv(input int dim, input int word);
        return (dim + 1) / word;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_TAIL = 2'd2
    } collector_state_t;

endpackage
`default_nettype wire

// File: rtl/core_result_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : core_result_collector_if
// Description : Core-side store port and downstream word stream of the
//               result collector.
// Revision    : 1.0 - initial release
// ============================================================================
interface core_result_collector_if
    import hpu_pkg::*;
#(
    parameter int DIM  = c_DIM_DEFAULT,
    parameter int WORD = c_WORD_DEFAULT
);
    logic            store;
    logic [DIM:0]    core_result;
    logic            last;
    logic            full;
    logic            put_v;
    logic [WORD-1:0] put_d;
    logic            put_last;
    logic            put_ready;

    modport master (
        output store, core_result, last, put_ready,
        input  full, put_v, put_d, put_last
    );

    modport slave (
        input  store, core_result, last, put_ready,
        output full, put_v, put_d, put_last
    );
endinterface
`default_nettype wire

// File: rtl/vec_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vec_fifo
// Description : Whole-vector FIFO; the caller guarantees push only when not
//               full and pop only when non-empty.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_fifo
    import hpu_pkg::*;
#(
    parameter int WIDTH = c_DIM_DEFAULT + 1,
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       push,
    input  wire logic                       pop,
    input  wire logic [WIDTH-1:0]           din,
    output logic      [$clog2(DEPTH+1)-1:0] count,
    output logic      [WIDTH-1:0]           head
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_CNT_W'(push) - c_CNT_W'(pop);
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/core_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : core_result_collector
// Description : Buffers whole hypervectors from the core and serialises them
//               LS word first onto a ready/valid word stream with end marking.
//               Optional: COLLECTOR_OVERFLOW_EN adds a sticky overflow output.
// Revision    : 1.0 - initial release
// ============================================================================
module core_result_collector
    import hpu_pkg::*;
#(
    parameter int DIM   = c_DIM_DEFAULT,
    parameter int WORD  = c_WORD_DEFAULT,
    parameter int DEPTH = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    core_result_collector_if.slave  bus
`ifdef COLLECTOR_OVERFLOW_EN
    ,
    output logic                    overflow
`endif
);

    localparam int c_WPV    = wpv(DIM, WORD);
    localparam int c_WCNT_W = (c_WPV > 1) ? $clog2(c_WPV) : 1;
    localparam int c_CNT_W  = $clog2(DEPTH + 1);
    localparam logic [c_WCNT_W-1:0] c_WORD_END = c_WCNT_W'(c_WPV - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);

    generate
        if (((DIM + 1) % WORD) != 0) begin : g_cfg_check
            $error("core_result_collector: DIM+1 must be a multiple of WORD");
        end
    endgenerate

    collector_state_t    r_state;
    collector_state_t    w_state_next;
    logic [c_WCNT_W-1:0] r_word;
    logic                r_last_pend;
    logic                r_full;
    logic                r_stalled;
    logic                r_held_last;
    logic [c_CNT_W-1:0]  w_count;
    logic [c_CNT_W-1:0]  w_count_next;
    logic [DIM:0]        w_head;
    logic [WORD-1:0]     w_words [c_WPV];
    logic                w_push;
    logic                w_pop;
    logic                w_xfer;
    logic                w_word_end;
    logic                w_last_in;
    logic                w_last_raw;

    assign w_push       = bus.store & ~r_full & ~rst;
    assign w_last_in    = bus.last & ~rst;
    assign w_xfer       = bus.put_v & bus.put_ready;
    assign w_word_end   = (r_word == c_WORD_END);
    assign w_pop        = (r_state == ST_SEND) & w_xfer & w_word_end;
    assign w_count_next = w_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

    vec_fifo #(
        .WIDTH (DIM + 1),
        .DEPTH (DEPTH)
    ) u_vec_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.core_result),
        .count (w_count),
        .head  (w_head)
    );

    generate
        for (genvar g = 0; g < c_WPV; g++) begin : g_words
            assign w_words[g] = w_head[g*WORD +: WORD];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A push into an empty FIFO is seen directly so the first word is offered
    // on the cycle right after the store.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_push || (w_count != '0)) begin
                    w_state_next = ST_SEND;
                end else if (r_last_pend) begin
                    w_state_next = ST_TAIL;
                end
            end
            ST_SEND: begin
                if (w_pop) begin
                    w_state_next = (w_count_next != '0) ? ST_SEND : ST_IDLE;
                end
            end
            ST_TAIL: begin
                if (bus.put_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.put_v  = 1'b0;
        bus.put_d  = '0;
        w_last_raw = 1'b0;
        case (r_state)
            ST_SEND: begin
                bus.put_v  = 1'b1;
                bus.put_d  = w_words[r_word];
                w_last_raw = w_word_end & r_last_pend & (w_count == c_CNT_ONE);
            end
            ST_TAIL: begin
                bus.put_v  = 1'b1;
                w_last_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // While stalled, put_last keeps the value first offered for this word; a
    // late last then falls through to a trailing zero word instead.
    assign bus.put_last = r_stalled ? r_held_last : w_last_raw;
    assign bus.full     = r_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word      <= '0;
            r_last_pend <= 1'b0;
            r_full      <= 1'b0;
            r_stalled   <= 1'b0;
            r_held_last <= 1'b0;
        end else begin
            if ((r_state == ST_SEND) && w_xfer) begin
                r_word <= w_word_end ? '0 : r_word + 1'b1;
            end
            if (w_last_in) begin
                r_last_pend <= 1'b1;
            end else if (w_xfer && bus.put_last) begin
                r_last_pend <= 1'b0;
            end
            r_full      <= (w_count_next == c_CNT_FULL);
            r_stalled   <= bus.put_v & ~bus.put_ready;
            r_held_last <= bus.put_last;
        end
    end

`ifdef COLLECTOR_OVERFLOW_EN
    logic r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (bus.store && r_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_result_collector
// Description : Directed self-checking bench for core_result_collector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_result_collector;

    localparam int c_DIM   = 1023;
    localparam int c_WORD  = 32;
    localparam int c_DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;

    logic [31:0] rx_d    [$];
    logic        rx_last [$];
    logic        rx_full [$];

    core_result_collector_if #(.DIM(c_DIM), .WORD(c_WORD)) bus ();

`ifdef COLLECTOR_OVERFLOW_EN
    logic overflow;
`endif

    core_result_collector #(
        .DIM   (c_DIM),
        .WORD  (c_WORD),
        .DEPTH (c_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef COLLECTOR_OVERFLOW_EN
        ,
        .overflow (overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [c_DIM:0] mkvec(input logic [31:0] base);
        logic [c_DIM:0] v;
        for (int k = 0; k < 32; k++) begin
            v[k*32 +: 32] = base + 32'(k);
        end
        return v;
    endfunction

    task automatic do_reset();
        rst             = 1'b1;
        bus.store       = 1'b0;
        bus.last        = 1'b0;
        bus.put_ready   = 1'b0;
        bus.core_result = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0,1 repeating
    task automatic collect(input int nwords, input int mode);
        int          cyc   = 0;
        int          got   = 0;
        logic        stall = 1'b0;
        logic [31:0] hd    = '0;
        logic        hl    = 1'b0;
        rx_d.delete();
        rx_last.delete();
        rx_full.delete();
        while ((got < nwords) && (cyc < 2000)) begin
            bus.put_ready = (mode == 0) ? 1'b1 : (((cyc % 4) == 0) || ((cyc % 4) == 3));
            #0;
            if (stall) begin
                check("hold_v", bus.put_v, 1'b1);
                check("hold_d", bus.put_d, hd);
                check("hold_last", bus.put_last, hl);
            end
            rx_full.push_back(bus.full);
            if (bus.put_v && bus.put_ready) begin
                rx_d.push_back(bus.put_d);
                rx_last.push_back(bus.put_last);
                got++;
            end
            stall = bus.put_v && !bus.put_ready;
            hd    = bus.put_d;
            hl    = bus.put_last;
            tick();
            cyc++;
        end
        n_cyc         = cyc;
        bus.put_ready = 1'b1;
        check("rx_count", got, nwords);
    endtask

    initial begin
        int n_last;
        do_reset();
        check("rst_full", bus.full, 1'b0);
        check("rst_put_v", bus.put_v, 1'b0);
        check("rst_put_last", bus.put_last, 1'b0);
        check("rst_put_d", bus.put_d, 32'h0);
`ifdef COLLECTOR_OVERFLOW_EN
        check("rst_overflow", overflow, 1'b0);
`endif

        // single vector, word k = k
        bus.store       = 1'b1;
        bus.core_result = mkvec(32'h0);
        bus.put_ready   = 1'b1;
        #1;
        check("single_pv_pre", bus.put_v, 1'b0);
        tick();
        bus.store = 1'b0;
        check("single_pv_rise", bus.put_v, 1'b1);
        collect(32, 0);
        check("single_cycles", n_cyc, 32);
        for (int k = 0; k < rx_d.size(); k++) begin
            check($sformatf("single_d%0d", k), rx_d[k], 32'(k));
            check($sformatf("single_last%0d", k), rx_last[k], 1'b0);
        end
        check("single_idle", bus.put_v, 1'b0);

        // backpressure
        do_reset();
        bus.store       = 1'b1;
        bus.core_result = mkvec(32'h100);
        tick();
        bus.store = 1'b0;
        collect(32, 1);
        for (int k = 0; k < rx_d.size(); k++) begin
            check($sformatf("bp_d%0d", k), rx_d[k], 32'h100 + 32'(k));
        end
        tick();
        check("bp_idle", bus.put_v, 1'b0);

        // fill to DEPTH, drop a fifth store, drain
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.store       = 1'b1;
            bus.core_result = mkvec(32'(i + 1) << 16);
            tick();
            if (i == 2) check("fill_full_3", bus.full, 1'b0);
        end
        check("fill_full_4", bus.full, 1'b1);
        bus.core_result = mkvec(32'hDEAD_0000);
        tick();
        bus.store = 1'b0;
        check("fill_full_5", bus.full, 1'b1);
`ifdef COLLECTOR_OVERFLOW_EN
        check("fill_overflow", overflow, 1'b1);
`endif
        collect(128, 0);
        check("fill_full_pre_pop", rx_full[31], 1'b1);
        check("fill_full_post_pop", rx_full[32], 1'b0);
        for (int k = 0; k < rx_d.size(); k++) begin
            check($sformatf("fill_d%0d", k), rx_d[k], ((32'(k / 32) + 32'd1) << 16) + 32'(k % 32));
            check($sformatf("fill_last%0d", k), rx_last[k], 1'b0);
        end
        tick();
        check("fill_no_fifth", bus.put_v, 1'b0);

        // store and last together on the second vector
        do_reset();
        bus.store       = 1'b1;
        bus.core_result = mkvec(32'hA000);
        tick();
        bus.core_result = mkvec(32'hB000);
        bus.last        = 1'b1;
        tick();
        bus.store = 1'b0;
        bus.last  = 1'b0;
        collect(64, 0);
        n_last = 0;
        for (int k = 0; k < rx_last.size(); k++) begin
            if (rx_last[k]) n_last++;
        end
        check("order_last_cnt", n_last, 1);
        check("order_last63", rx_last[63], 1'b1);
        check("order_d0", rx_d[0], 32'hA000);
        check("order_d63", rx_d[63], 32'hB01F);
        for (int i = 0; i < 4; i++) begin
            check("order_no_tail", bus.put_v, 1'b0);
            tick();
        end

        // empty run
        do_reset();
        bus.put_ready = 1'b1;
        bus.last      = 1'b1;
        tick();
        bus.last = 1'b0;
        collect(1, 0);
        check("empty_d", rx_d[0], 32'h0);
        check("empty_last", rx_last[0], 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("empty_once", bus.put_v, 1'b0);
            tick();
        end

        // reset mid-SEND, store during reset ignored, then restart
        do_reset();
        bus.store       = 1'b1;
        bus.core_result = mkvec(32'h2000);
        tick();
        bus.store = 1'b0;
        collect(10, 0);
        check("rst_mid_word10", bus.put_d, 32'h200A);
        rst             = 1'b1;
        bus.store       = 1'b1;
        bus.core_result = mkvec(32'h5555_0000);
        tick();
        check("rst_mid_put_v", bus.put_v, 1'b0);
        check("rst_mid_full", bus.full, 1'b0);
        check("rst_mid_put_d", bus.put_d, 32'h0);
        rst       = 1'b0;
        bus.store = 1'b0;
        tick();
        check("rst_store_ignored", bus.put_v, 1'b0);
        bus.store       = 1'b1;
        bus.core_result = mkvec(32'h3000);
        tick();
        bus.store = 1'b0;
        collect(32, 0);
        for (int k = 0; k < rx_d.size(); k++) begin
            check($sformatf("restart_d%0d", k), rx_d[k], 32'h3000 + 32'(k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
